// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared requester ids, widths and the CDB broadcast record
package cdb_arbiter_pkg;
    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 16;
    localparam int ROB_IDX_W = 4;
    localparam int REQ_ID_W  = $clog2(NUM_REQ);

    typedef logic [REQ_ID_W-1:0] req_id_t;

    localparam req_id_t REQ_FXU0 = 2'd0;
    localparam req_id_t REQ_FXU1 = 2'd1;
    localparam req_id_t REQ_LSU  = 2'd2;
    localparam req_id_t REQ_BR   = 2'd3;

    // one broadcast on the common data bus, as seen by the ROB and reservation stations
    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [DATA_W-1:0]    value;
        req_id_t              src;
    } cdb_rec_t;

    // distance of a ROB entry from the head with 4-bit wrap; smaller means older
    function automatic logic [ROB_IDX_W-1:0] rob_age(
        input logic [ROB_IDX_W-1:0] idx,
        input logic [ROB_IDX_W-1:0] head
    );
        return idx - head;
    endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: requester handshake, ROB control and CDB broadcast signals
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic [NUM_REQ-1:0]           req_valid_flat;
    logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx_flat;
    logic [NUM_REQ*DATA_W-1:0]    req_value_flat;
    logic [NUM_REQ-1:0]           req_ready_flat;
    logic [ROB_IDX_W-1:0]         rob_head_idx;
    logic                         rob_ready;
    logic                         flush;
    logic                         cdb_valid;
    logic [ROB_IDX_W-1:0]         cdb_rob_idx;
    logic [DATA_W-1:0]            cdb_value;
    req_id_t                      cdb_src;

    modport master (
        output req_valid_flat, req_rob_idx_flat, req_value_flat, rob_head_idx, rob_ready, flush,
        input  req_ready_flat, cdb_valid, cdb_rob_idx, cdb_value, cdb_src
    );

    modport slave (
        input  req_valid_flat, req_rob_idx_flat, req_value_flat, rob_head_idx, rob_ready, flush,
        output req_ready_flat, cdb_valid, cdb_rob_idx, cdb_value, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter_rr_priority_pick.sv
// rr_priority_pick: 4-way rotating-priority picker returning one-hot grant and encoded id
module rr_priority_pick
    import cdb_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            ptr,
    output logic [NUM_REQ-1:0] grant,
    output req_id_t            id,
    output logic               any
);
    req_id_t cand;

    // walk offsets from farthest to nearest so the requester closest to ptr is kept last
    always_comb begin
        id   = ptr;
        cand = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = req_id_t'(ptr + req_id_t'(k));
            if (req[cand]) id = cand;
        end
    end

    assign any   = |req;
    assign grant = any ? (NUM_REQ'(1) << id) : '0;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin result-bus arbiter with ROB backpressure and flush; CDB_AGE_PRIORITY_EN selects oldest-first
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input logic          clk,
    input logic          rst,
    cdb_arbiter_if.slave bus
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [ROB_IDX_W-1:0] req_idx [NUM_REQ];
    logic [DATA_W-1:0]    req_val [NUM_REQ];
    logic [NUM_REQ-1:0]   rr_grant, pick_grant, grant, ready_flat;
    req_id_t              rr_id, pick_id;
    logic                 rr_any, pick_any;
    logic                 slot_free, grant_en, granted;
    cdb_rec_t             cdb_d, cdb_q;
    req_id_t              rr_ptr_d, rr_ptr_q;

    // unpack flat ports: requester 0 occupies the most-significant slice
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = bus.req_valid_flat[NUM_REQ-1-i];
            req_idx[i]   = bus.req_rob_idx_flat[(NUM_REQ-1-i)*ROB_IDX_W +: ROB_IDX_W];
            req_val[i]   = bus.req_value_flat[(NUM_REQ-1-i)*DATA_W +: DATA_W];
        end
    end

    rr_priority_pick u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (rr_grant),
        .id    (rr_id),
        .any   (rr_any)
    );

`ifdef CDB_AGE_PRIORITY_EN
    logic [ROB_IDX_W-1:0] best_age;
    logic                 unused_rr;

    assign unused_rr = ^{rr_grant, rr_id, rr_any};

    // oldest valid result wins; scanning downward with <= lets the lower id win ties
    always_comb begin
        best_age = '1;
        pick_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && rob_age(req_idx[i], bus.rob_head_idx) <= best_age) begin
                best_age = rob_age(req_idx[i], bus.rob_head_idx);
                pick_id  = req_id_t'(i);
            end
        end
    end

    assign pick_any   = |req_valid;
    assign pick_grant = pick_any ? (NUM_REQ'(1) << pick_id) : '0;
`else
    logic unused_head;

    assign unused_head = ^bus.rob_head_idx;
    assign pick_id     = rr_id;
    assign pick_any    = rr_any;
    assign pick_grant  = rr_grant;
`endif

    assign slot_free = ~cdb_q.valid | bus.rob_ready;
    assign grant_en  = slot_free & ~bus.flush & ~rst;
    assign grant     = grant_en ? pick_grant : '0;
    assign granted   = |grant;

    // ready is the grant itself, repacked with requester 0 in the MSB
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) ready_flat[NUM_REQ-1-i] = grant[i];
    end

    // flush drops any broadcast and resets fairness; otherwise load the winner or go idle when the slot drains
    always_comb begin
        cdb_d    = cdb_q;
        rr_ptr_d = rr_ptr_q;
        if (bus.flush) begin
            cdb_d.valid = 1'b0;
            rr_ptr_d    = '0;
        end else if (granted) begin
            cdb_d.valid   = 1'b1;
            cdb_d.rob_idx = req_idx[pick_id];
            cdb_d.value   = req_val[pick_id];
            cdb_d.src     = pick_id;
            rr_ptr_d      = req_id_t'(pick_id + 1'b1);
        end else if (slot_free) begin
            cdb_d.valid = 1'b0;
        end
    end

    // output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            cdb_q    <= cdb_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.req_ready_flat = ready_flat;
    assign bus.cdb_valid      = cdb_q.valid;
    assign bus.cdb_rob_idx    = cdb_q.rob_idx;
    assign bus.cdb_value      = cdb_q.value;
    assign bus.cdb_src        = cdb_q.src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of reset, contention, backpressure, flush, fairness and winner selection
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    cdb_arbiter_if bus();

    cdb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] idx, input logic [15:0] val);
        bus.req_valid_flat[3-i]             = v;
        bus.req_rob_idx_flat[(3-i)*4 +: 4]  = idx;
        bus.req_value_flat[(3-i)*16 +: 16]  = val;
    endtask

    task automatic chk_cdb(input string tag, input logic v, input logic [3:0] idx, input logic [15:0] val, input req_id_t src);
        chk({tag, ".valid"}, 32'(bus.cdb_valid), 32'(v));
        chk({tag, ".idx"}, 32'(bus.cdb_rob_idx), 32'(idx));
        chk({tag, ".value"}, 32'(bus.cdb_value), 32'(val));
        chk({tag, ".src"}, 32'(bus.cdb_src), 32'(src));
    endtask

    logic [3:0]  c_idx [4] = '{4'd3, 4'd5, 4'd7, 4'd9};
    logic [15:0] c_val [4] = '{16'h00A0, 16'h00B1, 16'h00C2, 16'h00D3};

    initial begin
        bus.req_valid_flat   = '0;
        bus.req_rob_idx_flat = '0;
        bus.req_value_flat   = '0;
        bus.rob_head_idx     = '0;
        bus.rob_ready        = 1'b1;
        bus.flush            = 1'b0;

        // reset: two cycles, with requests present during the second
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, c_idx[i], c_val[i]);
        #1;
        chk("rst_ready", 32'(bus.req_ready_flat), 32'h0);
        tick();
        chk_cdb("rst_cdb", 1'b0, 4'd0, 16'h0, REQ_FXU0);
        chk("rst_ptr", 32'(dut.rr_ptr_q), 32'h0);
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'd0, 16'h0);
        rst = 1'b0;
        #1;
        chk("idle_ready", 32'(bus.req_ready_flat), 32'h0);
        tick();
        chk("idle_valid", 32'(bus.cdb_valid), 32'h0);
        chk("idle_ptr", 32'(dut.rr_ptr_q), 32'h0);

        // contention: all four valid, grants rotate 0,1,2,3
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, c_idx[i], c_val[i]);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont_ready%0d", i), 32'(bus.req_ready_flat), 32'(4'b1000 >> i));
            tick();
            chk_cdb($sformatf("cont_cdb%0d", i), 1'b1, c_idx[i], c_val[i], req_id_t'(i));
        end
        chk("cont_ptr", 32'(dut.rr_ptr_q), 32'h0);
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'd0, 16'h0);
        tick();
        chk_cdb("idle_hold", 1'b0, 4'd9, 16'h00D3, REQ_BR);

        // backpressure: FXU1 broadcast held while the ROB stalls, LSU waits
        set_req(1, 1'b1, 4'd6, 16'h1234);
        #1;
        chk("bp_ready_fxu1", 32'(bus.req_ready_flat), 32'b0100);
        tick();
        chk_cdb("bp_first", 1'b1, 4'd6, 16'h1234, REQ_FXU1);
        set_req(1, 1'b0, 4'd0, 16'h0);
        set_req(2, 1'b1, 4'd8, 16'h5678);
        bus.rob_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp_stall_ready%0d", c), 32'(bus.req_ready_flat), 32'h0);
            tick();
            chk_cdb($sformatf("bp_hold%0d", c), 1'b1, 4'd6, 16'h1234, REQ_FXU1);
        end
        bus.rob_ready = 1'b1;
        #1;
        chk("bp_ready_lsu", 32'(bus.req_ready_flat), 32'b0010);
        tick();
        chk_cdb("bp_lsu", 1'b1, 4'd8, 16'h5678, REQ_LSU);
        set_req(2, 1'b0, 4'd0, 16'h0);

        // flush: held broadcast dropped, pointer back to FXU0
        bus.rob_ready = 1'b0;
        tick();
        chk("fl_held", 32'(bus.cdb_valid), 32'h1);
        chk("fl_ptr_before", 32'(dut.rr_ptr_q), 32'h3);
        bus.flush = 1'b1;
        set_req(3, 1'b1, 4'd11, 16'hBEEF);
        set_req(0, 1'b1, 4'd1, 16'h0F0F);
        #1;
        chk("fl_ready", 32'(bus.req_ready_flat), 32'h0);
        tick();
        chk("fl_valid", 32'(bus.cdb_valid), 32'h0);
        chk("fl_ptr", 32'(dut.rr_ptr_q), 32'h0);
        bus.flush = 1'b0;
        #1;
        chk("fl_after_ready", 32'(bus.req_ready_flat), 32'b1000);
        tick();
        chk_cdb("fl_after_cdb", 1'b1, 4'd1, 16'h0F0F, REQ_FXU0);
        set_req(3, 1'b0, 4'd0, 16'h0);

        // fairness: FXU0 stays valid, LSU joins and must win within two cycles
        bus.rob_ready = 1'b1;
        #1;
        chk("fair_fxu0", 32'(bus.req_ready_flat), 32'b1000);
        tick();
        set_req(2, 1'b1, 4'd12, 16'hCAFE);
        begin
            logic got_lsu;
            got_lsu = 1'b0;
            for (int c = 0; c < 2 && !got_lsu; c++) begin
                #1;
                got_lsu = bus.req_ready_flat[1];
                tick();
            end
            chk("fair_lsu_granted", 32'(got_lsu), 32'h1);
        end
        chk_cdb("fair_lsu_cdb", 1'b1, 4'd12, 16'hCAFE, REQ_LSU);
        set_req(2, 1'b0, 4'd0, 16'h0);
        #1;
        chk("fair_fxu0_again", 32'(bus.req_ready_flat), 32'b1000);
        tick();
        set_req(0, 1'b0, 4'd0, 16'h0);

        // reset mid-operation discards the broadcast
        chk("mid_valid_before", 32'(bus.cdb_valid), 32'h1);
        rst = 1'b1;
        tick();
        chk_cdb("mid_rst", 1'b0, 4'd0, 16'h0, REQ_FXU0);
        rst = 1'b0;

        // winner selection with FXU0 idx 2 and branch idx 15, head 14
        bus.rob_head_idx = 4'd14;
        set_req(0, 1'b1, 4'd2, 16'h1111);
        set_req(3, 1'b1, 4'd15, 16'h2222);
`ifdef CDB_AGE_PRIORITY_EN
        #1;
        chk("age_first_ready", 32'(bus.req_ready_flat), 32'b0001);
        tick();
        chk_cdb("age_first", 1'b1, 4'd15, 16'h2222, REQ_BR);
        set_req(3, 1'b0, 4'd0, 16'h0);
        #1;
        chk("age_second_ready", 32'(bus.req_ready_flat), 32'b1000);
        tick();
        chk_cdb("age_second", 1'b1, 4'd2, 16'h1111, REQ_FXU0);
`else
        #1;
        chk("rr_first_ready", 32'(bus.req_ready_flat), 32'b1000);
        tick();
        chk_cdb("rr_first", 1'b1, 4'd2, 16'h1111, REQ_FXU0);
        set_req(0, 1'b0, 4'd0, 16'h0);
        #1;
        chk("rr_second_ready", 32'(bus.req_ready_flat), 32'b0001);
        tick();
        chk_cdb("rr_second", 1'b1, 4'd15, 16'h2222, REQ_BR);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Result-bus arbiter for the out-of-order core. Four execution units compete for one common data bus (CDB): FXU0, FXU1, LSU and branch. The winner's ROB index and 16-bit result are registered and broadcast once per cycle to the ROB and to the waiting operand owners. The block provides round-robin fairness, backpressure from the ROB, and a flush on branch mispredict.

Parameters:
- NUM_REQ, 4, number of requesters; fixed by the flat port widths, not for override.
- DATA_W, 16, result width.
- ROB_IDX_W, 4, ROB index width (16-entry ROB).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_flat  in  4  per-requester result valid.
- req_rob_idx_flat  in  16  per-requester destination ROB index, 4 bits each.
- req_value_flat  in  64  per-requester result, 16 bits each.
- req_ready_flat  out  4  per-requester grant/accept (combinational).
- rob_head_idx  in  4  current ROB head; used only with the optional feature.
- rob_ready  in  1  ROB can accept a broadcast this cycle.
- flush  in  1  mispredict flush.
- cdb_valid  out  1  broadcast valid (registered).
- cdb_rob_idx  out  4  broadcast ROB index.
- cdb_value  out  16  broadcast value.
- cdb_src  out  2  winning requester id.

Behaviour:
- Requester ids: 0=FXU0, 1=FXU1, 2=LSU, 3=branch.
- Flat packing: requester 0 occupies the most-significant slice, requester 3 the least-significant slice. This applies to every flat port.
- Clocking and reset: all state updates on posedge clk. rst is synchronous and active-high.
- On rst: cdb_valid=0, cdb_rob_idx=0, cdb_value=0, cdb_src=0, rr_ptr=0. req_ready_flat is 0 during the rst cycle.
- Output register state:
  - "slot_free" = ~cdb_valid | rob_ready.
  - Broadcast is consumed when cdb_valid & rob_ready.
- Grant:
  - Computed only when slot_free & ~flush & ~rst.
  - At most one requester is granted per cycle.
  - Round-robin search starts at rr_ptr and proceeds upward modulo 4.
  - req_ready[i] = grant[i].
- Requester rules:
  - req_ready may depend on req_valid.
  - A requester must not make req_valid depend on req_ready.
  - A requester must hold valid, index and value stable until it is accepted.
- Transfer: valid & ready on requester i at edge N gives cdb_valid=1 with that index, value and src=i from edge N, i.e. 1-cycle latency.
- Pointer update: after a grant to i, rr_ptr <= (i+1) mod 4. With no grant, rr_ptr is unchanged.
- Backpressure: cdb_valid & ~rob_ready means the output register holds all fields and no grant is issued.
- Idle: slot_free with no requests gives cdb_valid <= 0; idx, value and src hold their previous values.
- Full throughput: rob_ready held high supports back-to-back broadcasts every cycle.
- Flush:
  - No grants in the flush cycle.
  - At the next edge: cdb_valid <= 0 (a held broadcast is dropped) and rr_ptr <= 0.
  - Flush has priority over rob_ready and over all requests.
- Starvation bound: any requester held valid waits at most 3 granting cycles.
- rst asserted mid-operation discards any held broadcast; there is no partial state.

Optional Feature:
Macro CDB_AGE_PRIORITY_EN.
- Defined:
  - The winner is the valid requester with the smallest age = (req_rob_idx - rob_head_idx) mod 16, using 4-bit wrap arithmetic.
  - On equal age (illegal, but defined), the lower requester id wins.
  - rr_ptr is still updated but ignored.
- Undefined: pure round-robin as above; rob_head_idx is unused.

Decomposition:
- Shared package:
  - Requester id constants: REQ_FXU0=0, REQ_FXU1=1, REQ_LSU=2, REQ_BR=3.
  - DATA_W, ROB_IDX_W.
  - Typedef of a cdb record {valid, rob_idx, value, src}, shared with the ROB and the reservation stations.
- Sub-module: rr_priority_pick. Combinational 4-way rotate-priority picker taking the request vector and pointer, returning a one-hot grant and an encoded id. It is reused by the dispatch logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all valid=0 → cdb_valid=0, req_ready_flat=0000, rr_ptr=0.
- Contention:
  - Stimulus: all 4 valid, idx {3,5,7,9}, values {A0,B1,C2,D3}, rob_ready=1.
  - Required: grants in order 0,1,2,3 on consecutive cycles; cdb shows (3,A0,src0) then (5,B1,src1), (7,C2,src2), (9,D3,src3).
- Backpressure:
  - Stimulus: FXU1 broadcasts idx 6 value 1234; rob_ready=0 for 3 cycles while LSU is valid.
  - Required: cdb holds (6,1234,src1) for 3 cycles and LSU ready=0; the cycle rob_ready=1, LSU is granted and cdb shows LSU data next cycle.
- Flush:
  - Stimulus: cdb_valid=1 held with rob_ready=0, flush=1 for one cycle with branch valid.
  - Required: branch ready=0; next cycle cdb_valid=0 and rr_ptr=0; the following cycle FXU0, if valid, wins over branch.
- Fairness: FXU0 valid continuously and LSU valid once → LSU is granted within 2 cycles of asserting valid.
- With CDB_AGE_PRIORITY_EN:
  - Stimulus: head=14, FXU0 idx 2 (age 4), branch idx 15 (age 1).
  - Required: branch is granted first, FXU0 next cycle.
